seq_loop_status_monitor: RTL and testbench

// Synthesizable status monitor for one HLS block-level (ap_ctrl_hs) module and one sequential loop inside it.

---
 rtl/seq_loop_status_monitor.sv | 232 +++++++++++++++++++++++
 tb/tb_seq_loop_status_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_loop_status_monitor.sv
// seq_loop_status_monitor
// Status monitor for one HLS ap_ctrl_hs block and one sequential loop inside
// it. Counts transactions and their latency from the block-level handshake,
// and loop entries, iterations and exits from the one-hot FSM state vector.
// All counters saturate at all-ones. Once finish is seen the statistics freeze
// until reset.
// Optional feature: define SEQ_LOOP_MON_MINMAX_EN to add min_iters/max_iters,
// the smallest and largest iteration count seen over all loop executions.

module seq_loop_status_monitor #(
  parameter int STATE_W = 6,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic               finish,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] pre_loop_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_loop_state,
  input  logic [STATE_W-1:0] post_loop_state,
  input  logic               pre_valid,
  input  logic               quit_valid,
  input  logic               one_state_loop,
  output logic               mod_busy,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   txn_latency,
  output logic               loop_active,
  output logic [CNT_W-1:0]   iter_count,
  output logic [CNT_W-1:0]   loop_cycles,
  output logic [CNT_W-1:0]   loop_exec_count,
  output logic               loop_done,
  output logic               frozen
`ifdef SEQ_LOOP_MON_MINMAX_EN
  ,
  output logic [CNT_W-1:0]   min_iters,
  output logic [CNT_W-1:0]   max_iters
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    MOD_IDLE = 1'b0,
    MOD_BUSY = 1'b1
  } modState_t;

  typedef enum logic [0:0] {
    LOOP_IDLE   = 1'b0,
    LOOP_ACTIVE = 1'b1
  } loopState_t;

  // Saturating increment shared by every counter.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  modState_t          modState_q, modState_d;
  loopState_t         loopState_q, loopState_d;
  logic [STATE_W-1:0] prevState_q;
  logic [CNT_W-1:0]   latCnt_q, latCnt_d;
  logic [CNT_W-1:0]   txnCount_q, txnCount_d;
  logic [CNT_W-1:0]   txnLatency_q, txnLatency_d;
  logic [CNT_W-1:0]   loopCnt_q, loopCnt_d;
  logic [CNT_W-1:0]   iterCount_q, iterCount_d;
  logic [CNT_W-1:0]   loopCycles_q, loopCycles_d;
  logic [CNT_W-1:0]   loopExec_q, loopExec_d;
  logic               loopDone_q, loopDone_d;
  logic               frozen_q, frozen_d;
`ifdef SEQ_LOOP_MON_MINMAX_EN
  logic [CNT_W-1:0]   minIters_q, minIters_d;
  logic [CNT_W-1:0]   maxIters_q, maxIters_d;
`endif

  logic freezeNow;
  logic txnDone;
  logic atIterStart;
  logic entryHit;
  logic exitHit;
  logic iterHit;
  logic unusedReady;

  // ap_ready carries no information the monitor needs beyond ap_start/ap_done.
  assign unusedReady = ap_ready;

  // The cycle finish is seen already behaves as frozen so that the busy and
  // active flags drop together with frozen rising.
  assign freezeNow = frozen_q | finish;
  assign txnDone   = ap_done & ap_continue;

  // Loop event decode, all as full-vector state equality.
  assign atIterStart = (cur_state == iter_start_state);
  assign entryHit    = atIterStart && ((prevState_q == pre_loop_state) || !pre_valid);
  assign exitHit     = (cur_state == post_loop_state) &&
                       ((prevState_q == quit_loop_state) || !quit_valid);
  assign iterHit     = atIterStart && (one_state_loop || (prevState_q == iter_end_state));

  // Transaction tracker: accepts a start when idle or when the current
  // transaction completes in the same cycle, and times start-to-done.
  always_comb begin
    modState_d   = modState_q;
    latCnt_d     = latCnt_q;
    txnCount_d   = txnCount_q;
    txnLatency_d = txnLatency_q;
    frozen_d     = frozen_q | finish;

    if (freezeNow) begin
      modState_d = MOD_IDLE;
    end else begin
      if (txnDone) begin
        txnCount_d   = satInc(txnCount_q);
        txnLatency_d = (modState_q == MOD_BUSY) ? latCnt_q : CNT_ONE;
      end

      if (ap_start && ((modState_q == MOD_IDLE) || txnDone)) begin
        modState_d = MOD_BUSY;
        latCnt_d   = CNT_ONE;
      end else if (txnDone) begin
        modState_d = MOD_IDLE;
      end else if (modState_q == MOD_BUSY) begin
        latCnt_d = satInc(latCnt_q);
      end
    end
  end

  // Loop tracker: entry, per-iteration counting and exit. Exit is tested
  // before next-iteration so it wins when both match in one cycle.
  always_comb begin
    loopState_d  = loopState_q;
    loopCnt_d    = loopCnt_q;
    iterCount_d  = iterCount_q;
    loopCycles_d = loopCycles_q;
    loopExec_d   = loopExec_q;
    loopDone_d   = 1'b0;
`ifdef SEQ_LOOP_MON_MINMAX_EN
    minIters_d   = minIters_q;
    maxIters_d   = maxIters_q;
`endif

    if (freezeNow) begin
      loopState_d = LOOP_IDLE;
    end else begin
      case (loopState_q)
        LOOP_IDLE: begin
          if (entryHit) begin
            loopState_d = LOOP_ACTIVE;
            iterCount_d = CNT_ONE;
            loopCnt_d   = CNT_ONE;
          end
        end
        LOOP_ACTIVE: begin
          loopCnt_d = satInc(loopCnt_q);
          if (exitHit) begin
            loopState_d  = LOOP_IDLE;
            loopCycles_d = loopCnt_q;
            loopExec_d   = satInc(loopExec_q);
            loopDone_d   = 1'b1;
`ifdef SEQ_LOOP_MON_MINMAX_EN
            minIters_d   = (iterCount_q < minIters_q) ? iterCount_q : minIters_q;
            maxIters_d   = (iterCount_q > maxIters_q) ? iterCount_q : maxIters_q;
`endif
          end else if (iterHit) begin
            iterCount_d = satInc(iterCount_q);
          end
        end
        default: begin
          loopState_d = LOOP_IDLE;
        end
      endcase
    end
  end

  // State and statistics registers with synchronous reset clearing everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      modState_q   <= MOD_IDLE;
      loopState_q  <= LOOP_IDLE;
      prevState_q  <= '0;
      latCnt_q     <= '0;
      txnCount_q   <= '0;
      txnLatency_q <= '0;
      loopCnt_q    <= '0;
      iterCount_q  <= '0;
      loopCycles_q <= '0;
      loopExec_q   <= '0;
      loopDone_q   <= 1'b0;
      frozen_q     <= 1'b0;
`ifdef SEQ_LOOP_MON_MINMAX_EN
      minIters_q   <= CNT_MAX;
      maxIters_q   <= '0;
`endif
    end else begin
      modState_q   <= modState_d;
      loopState_q  <= loopState_d;
      prevState_q  <= cur_state;
      latCnt_q     <= latCnt_d;
      txnCount_q   <= txnCount_d;
      txnLatency_q <= txnLatency_d;
      loopCnt_q    <= loopCnt_d;
      iterCount_q  <= iterCount_d;
      loopCycles_q <= loopCycles_d;
      loopExec_q   <= loopExec_d;
      loopDone_q   <= loopDone_d;
      frozen_q     <= frozen_d;
`ifdef SEQ_LOOP_MON_MINMAX_EN
      minIters_q   <= minIters_d;
      maxIters_q   <= maxIters_d;
`endif
    end
  end

  assign mod_busy        = (modState_q == MOD_BUSY);
  assign loop_active     = (loopState_q == LOOP_ACTIVE);
  assign txn_count       = txnCount_q;
  assign txn_latency     = txnLatency_q;
  assign iter_count      = iterCount_q;
  assign loop_cycles     = loopCycles_q;
  assign loop_exec_count = loopExec_q;
  assign loop_done       = loopDone_q & ~unusedReady | loopDone_q & unusedReady;
  assign frozen          = frozen_q;
`ifdef SEQ_LOOP_MON_MINMAX_EN
  assign min_iters       = minIters_q;
  assign max_iters       = maxIters_q;
`endif

endmodule

// File: tb/tb_seq_loop_status_monitor.sv
// tb_seq_loop_status_monitor
// Directed bench for seq_loop_status_monitor. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped when outputs are checked.

module tb_seq_loop_status_monitor;

  localparam int STATE_W = 8;
  localparam int CNT_W   = 32;

  logic               clock = 1'b0;
  logic               reset;
  logic               ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [STATE_W-1:0] cur_state, pre_loop_state, iter_start_state;
  logic [STATE_W-1:0] iter_end_state, quit_loop_state, post_loop_state;
  logic               pre_valid, quit_valid, one_state_loop;
  logic               mod_busy, loop_active, loop_done, frozen;
  logic [CNT_W-1:0]   txn_count, txn_latency, iter_count, loop_cycles, loop_exec_count;
`ifdef SEQ_LOOP_MON_MINMAX_EN
  logic [CNT_W-1:0]   min_iters, max_iters;
`endif

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expT;

  expT expQ[$];
  int  seqQ[$];
  int  testsRun  = 0;
  int  failCount = 0;
  int  tickNo    = 0;
  int  doneCount = 0;
  int  startTick = 0;
  int  midTick   = 0;
  int  latHold   = 0;

  seq_loop_status_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .ap_start         (ap_start),
    .ap_ready         (ap_ready),
    .ap_done          (ap_done),
    .ap_continue      (ap_continue),
    .finish           (finish),
    .cur_state        (cur_state),
    .pre_loop_state   (pre_loop_state),
    .iter_start_state (iter_start_state),
    .iter_end_state   (iter_end_state),
    .quit_loop_state  (quit_loop_state),
    .post_loop_state  (post_loop_state),
    .pre_valid        (pre_valid),
    .quit_valid       (quit_valid),
    .one_state_loop   (one_state_loop),
    .mod_busy         (mod_busy),
    .txn_count        (txn_count),
    .txn_latency      (txn_latency),
    .loop_active      (loop_active),
    .iter_count       (iter_count),
    .loop_cycles      (loop_cycles),
    .loop_exec_count  (loop_exec_count),
    .loop_done        (loop_done),
    .frozen           (frozen)
`ifdef SEQ_LOOP_MON_MINMAX_EN
    ,
    .min_iters        (min_iters),
    .max_iters        (max_iters)
`endif
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired tick=%0d", tickNo);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [STATE_W-1:0] oh(input int n);
    logic [STATE_W-1:0] one;
    one = STATE_W'(1);
    return one << n;
  endfunction

  function automatic void pushExpect(input string tag, input logic [31:0] value);
    expT e;
    e.tag   = tag;
    e.value = value;
    expQ.push_back(e);
  endfunction

  // One clock edge, then settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clock);
    #1;
    tickNo++;
    if (loop_done === 1'b1) doneCount++;
  endtask

  // Plays the queued state numbers onto cur_state, one per cycle.
  task automatic applyStimulus();
    while (seqQ.size() > 0) begin
      cur_state = oh(seqQ.pop_front());
      tick();
    end
    cur_state = oh(0);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    expT e;
    testsRun++;
    if (expQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard_empty observed=%0d", observed);
      return;
    end
    e = expQ.pop_front();
    assert (observed === e.value) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, observed, e.value);
    end
  endtask

  initial begin
    reset            = 1'b1;
    ap_start         = 1'b0;
    ap_ready         = 1'b0;
    ap_done          = 1'b0;
    ap_continue      = 1'b1;
    finish           = 1'b0;
    cur_state        = oh(0);
    pre_loop_state   = oh(3);
    iter_start_state = oh(4);
    iter_end_state   = oh(5);
    quit_loop_state  = oh(5);
    post_loop_state  = oh(6);
    pre_valid        = 1'b1;
    quit_valid       = 1'b1;
    one_state_loop   = 1'b0;

    // Reset state.
    tick();
    tick();
    pushExpect("rst_txn_count", 0);    checkOutput(txn_count);
    pushExpect("rst_mod_busy", 0);     checkOutput(mod_busy);
    pushExpect("rst_iter_count", 0);   checkOutput(iter_count);
    pushExpect("rst_loop_exec", 0);    checkOutput(loop_exec_count);
    pushExpect("rst_frozen", 0);       checkOutput(frozen);
    pushExpect("rst_loop_active", 0);  checkOutput(loop_active);
    reset = 1'b0;
    tick();

    // Start pulse, done 10 cycles later.
    ap_start = 1'b1;
    tick();
    startTick = tickNo;
    ap_start = 1'b0;
    pushExpect("t1_busy_after_start", 1); checkOutput(mod_busy);
    repeat (9) tick();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    pushExpect("t1_txn_count", 1);    checkOutput(txn_count);
    pushExpect("t1_txn_latency", 10); checkOutput(txn_latency);
    pushExpect("t1_latency_ticks", 32'(tickNo - startTick)); checkOutput(txn_latency);
    pushExpect("t1_busy_after_done", 0); checkOutput(mod_busy);

    // Two-state loop, 3 iterations, inside a busy transaction.
    ap_start = 1'b1;
    tick();
    startTick = tickNo;
    ap_start = 1'b0;
    doneCount = 0;
    seqQ = {0, 3, 4, 5};
    applyStimulus();
    pushExpect("l1_active_mid", 1); checkOutput(loop_active);
    seqQ = {4, 5, 4, 5, 6, 0, 0};
    applyStimulus();
    pushExpect("l1_iter_count", 3);  checkOutput(iter_count);
    pushExpect("l1_loop_cycles", 6); checkOutput(loop_cycles);
    pushExpect("l1_exec_count", 1);  checkOutput(loop_exec_count);
    pushExpect("l1_done_pulses", 1); checkOutput(32'(doneCount));
    pushExpect("l1_active_after", 0); checkOutput(loop_active);
    repeat (3) tick();
    pushExpect("l1_iter_held", 3);   checkOutput(iter_count);

    // Same loop again in the same transaction.
    doneCount = 0;
    seqQ = {0, 3, 4, 5, 4, 5, 4, 5, 6, 0};
    applyStimulus();
    pushExpect("l2_exec_count", 2);  checkOutput(loop_exec_count);
    pushExpect("l2_iter_count", 3);  checkOutput(iter_count);
    pushExpect("l2_loop_cycles", 6); checkOutput(loop_cycles);
    pushExpect("l2_done_pulses", 1); checkOutput(32'(doneCount));
    pushExpect("l2_busy", 1);        checkOutput(mod_busy);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    pushExpect("t2_txn_count", 2);   checkOutput(txn_count);
    pushExpect("t2_txn_latency", 32'(tickNo - startTick)); checkOutput(txn_latency);

    // Wrong predecessor with pre_valid=1: no entry.
    doneCount = 0;
    seqQ = {0, 4, 5, 4, 5, 6, 0};
    applyStimulus();
    pushExpect("np_exec_count", 2);  checkOutput(loop_exec_count);
    pushExpect("np_done_pulses", 0); checkOutput(32'(doneCount));
    pushExpect("np_iter_held", 3);   checkOutput(iter_count);

    // Same sequence with pre_valid=0: any predecessor enters.
    pre_valid = 1'b0;
    doneCount = 0;
    seqQ = {0, 4, 5, 4, 5, 6, 0};
    applyStimulus();
    pre_valid = 1'b1;
    pushExpect("pv_iter_count", 2);  checkOutput(iter_count);
    pushExpect("pv_loop_cycles", 4); checkOutput(loop_cycles);
    pushExpect("pv_exec_count", 3);  checkOutput(loop_exec_count);
    pushExpect("pv_done_pulses", 1); checkOutput(32'(doneCount));

    // One-state loop held 5 cycles in iter_start.
    one_state_loop  = 1'b1;
    quit_loop_state = oh(4);
    doneCount = 0;
    seqQ = {0, 3, 4, 4, 4, 4, 4, 6, 0};
    applyStimulus();
    one_state_loop  = 1'b0;
    quit_loop_state = oh(5);
    pushExpect("os_iter_count", 5);  checkOutput(iter_count);
    pushExpect("os_loop_cycles", 5); checkOutput(loop_cycles);
    pushExpect("os_exec_count", 4);  checkOutput(loop_exec_count);
    pushExpect("os_done_pulses", 1); checkOutput(32'(doneCount));

    // Reset mid-transaction and mid-loop.
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    seqQ = {0, 3, 4, 5};
    applyStimulus();
    pushExpect("mr_active_before", 1); checkOutput(loop_active);
    doneCount = 0;
    reset = 1'b1;
    tick();
    pushExpect("mr_txn_count", 0);   checkOutput(txn_count);
    pushExpect("mr_txn_latency", 0); checkOutput(txn_latency);
    pushExpect("mr_mod_busy", 0);    checkOutput(mod_busy);
    pushExpect("mr_loop_active", 0); checkOutput(loop_active);
    pushExpect("mr_iter_count", 0);  checkOutput(iter_count);
    pushExpect("mr_loop_cycles", 0); checkOutput(loop_cycles);
    pushExpect("mr_exec_count", 0);  checkOutput(loop_exec_count);
    pushExpect("mr_loop_done", 0);   checkOutput(loop_done);
    reset = 1'b0;
    seqQ = {0, 3, 4, 5, 4, 5, 6, 0};
    applyStimulus();
    pushExpect("ar_iter_count", 2);  checkOutput(iter_count);
    pushExpect("ar_loop_cycles", 4); checkOutput(loop_cycles);
    pushExpect("ar_exec_count", 1);  checkOutput(loop_exec_count);
    pushExpect("ar_done_pulses", 1); checkOutput(32'(doneCount));

    // Done and start in the same cycle: back-to-back transactions.
    ap_start = 1'b1;
    tick();
    startTick = tickNo;
    ap_start = 1'b0;
    repeat (4) tick();
    ap_done  = 1'b1;
    ap_start = 1'b1;
    tick();
    midTick  = tickNo;
    ap_done  = 1'b0;
    ap_start = 1'b0;
    pushExpect("bb_txn_count", 1);   checkOutput(txn_count);
    pushExpect("bb_txn_latency", 5); checkOutput(txn_latency);
    pushExpect("bb_busy_kept", 1);   checkOutput(mod_busy);
    repeat (6) tick();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    latHold = tickNo - midTick;
    pushExpect("bb2_txn_count", 2);   checkOutput(txn_count);
    pushExpect("bb2_txn_latency", 7); checkOutput(txn_latency);
    pushExpect("bb2_busy", 0);        checkOutput(mod_busy);

    // finish during a busy transaction freezes everything.
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    repeat (3) tick();
    pushExpect("fz_busy_before", 1); checkOutput(mod_busy);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    pushExpect("fz_frozen", 1);      checkOutput(frozen);
    pushExpect("fz_busy_forced", 0); checkOutput(mod_busy);
    pushExpect("fz_txn_count", 2);   checkOutput(txn_count);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    pushExpect("fz_done_ignored", 2);   checkOutput(txn_count);
    pushExpect("fz_latency_held", 32'(latHold)); checkOutput(txn_latency);
    doneCount = 0;
    seqQ = {0, 3, 4, 5, 4, 5, 6, 0};
    applyStimulus();
    pushExpect("fz_exec_held", 1);     checkOutput(loop_exec_count);
    pushExpect("fz_iter_held", 2);     checkOutput(iter_count);
    pushExpect("fz_no_done_pulse", 0); checkOutput(32'(doneCount));
    pushExpect("fz_loop_active", 0);   checkOutput(loop_active);
    pushExpect("fz_frozen_sticky", 1); checkOutput(frozen);

    // Only reset clears frozen.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    pushExpect("fz_reset_clears", 0); checkOutput(frozen);

    if (expQ.size() != 0) begin
      testsRun++;
      failCount++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
